flit_monitor: RTL and testbench

FLIT_MONITOR -- requirements
Module: flit_monitor

---
 rtl/flit_monitor.sv | 86 ++++++++
 tb/tb_flit_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/flit_monitor.sv
// Monitor-port sink: timestamps valid flits and buffers them in a show-ahead FIFO
// with a ready/valid read port and a saturating overflow drop counter.
module flit_monitor #(
    parameter int DEPTH   = 8,
    parameter int STAMP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [33:0]              flit_in,
    input  logic                     enable,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [32:0]              out_flit,
    output logic [STAMP_W-1:0]       out_stamp,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     full,
    output logic                     empty,
    output logic [7:0]               drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [STAMP_W-1:0] stamp_q;
    logic [32:0]        flit_mem  [DEPTH];
    logic [STAMP_W-1:0] stamp_mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [7:0]         drop_q, drop_d;
    logic               push_req, pop, push_ok;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        push_req = flit_in[33] & enable;
        pop      = (count_q != '0) & out_ready;
        push_ok  = push_req & ((count_q != FULL_CNT) | pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            drop_d   = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok && !pop)      count_d = count_q + (AW+1)'(1);
            else if (!push_ok && pop) count_d = count_q - (AW+1)'(1);
            if (push_req && !push_ok && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stamp_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            stamp_q  <= stamp_q + STAMP_W'(1);
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: contents are only visible while count_q is nonzero.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            flit_mem[wr_ptr_q]  <= flit_in[32:0];
            stamp_mem[wr_ptr_q] <= stamp_q;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_flit   = out_valid ? flit_mem[rd_ptr_q]  : '0;
    assign out_stamp  = out_valid ? stamp_mem[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign drop_count = drop_q;
endmodule

// File: tb/tb_flit_monitor.sv
// Bench for flit_monitor: directed scenarios plus random traffic against a queue model.
module tb_flit_monitor;
    localparam int DEPTH = 8;

    logic        clk, rst, enable, clear, out_ready;
    logic [33:0] flit_in;
    logic        out_valid, full, empty;
    logic [32:0] out_flit;
    logic [15:0] out_stamp;
    logic [3:0]  fifo_count;
    logic [7:0]  drop_count;

    int errors = 0;
    int checks = 0;
    int edges  = 0;
    logic [32:0] mq_flit[$];
    logic [15:0] mq_stamp[$];
    int m_drop = 0;

    flit_monitor #(.DEPTH(DEPTH), .STAMP_W(16)) dut (
        .clk(clk), .rst(rst), .flit_in(flit_in), .enable(enable), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
        .out_stamp(out_stamp), .fifo_count(fifo_count), .full(full), .empty(empty),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] rnd33();
        return 33'({$urandom, $urandom});
    endfunction

    task automatic set_in(input logic v, input logic [32:0] body, input logic en,
                          input logic clr, input logic rdy);
        flit_in = {v, body}; enable = en; clear = clr; out_ready = rdy;
    endtask

    // Model advances one edge from the specification's rules; timestamp = edges since reset.
    task automatic step();
        logic [15:0] st;
        bit push, pop;
        st   = 16'(edges % 65536);
        push = flit_in[33] && enable;
        pop  = (mq_flit.size() != 0) && out_ready;
        if (clear) begin
            mq_flit.delete(); mq_stamp.delete(); m_drop = 0;
        end else begin
            if (pop) begin
                void'(mq_flit.pop_front()); void'(mq_stamp.pop_front());
            end
            if (push) begin
                if (mq_flit.size() < DEPTH) begin
                    mq_flit.push_back(flit_in[32:0]); mq_stamp.push_back(st);
                end else if (m_drop < 255) m_drop++;
            end
        end
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        edges = 0;
        mq_flit.delete(); mq_stamp.delete(); m_drop = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b1, 33'h1, 1'b1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h want 0", out_valid); end
        checks++; if (out_flit !== 33'h0) begin errors++; $display("FAIL reset_flit: got %0h want 0", out_flit); end
        checks++; if (out_stamp !== 16'h0) begin errors++; $display("FAIL reset_stamp: got %0h want 0", out_stamp); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++; if (full !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL reset_flags: got full=%0b empty=%0b want 0/1", full, empty); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        set_in(1'b0, 33'h0, 1'b1, 1'b0, 1'b0);
        release_reset();
    endtask

    task automatic test_single();
        repeat (5) step();
        set_in(1'b1, 33'h0_0000_0ABC, 1'b1, 1'b0, 1'b0);
        step();
        set_in(1'b0, 33'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0h want 1", out_valid); end
        checks++; if (out_flit !== 33'h0_0000_0ABC) begin errors++; $display("FAIL single_flit: got %0h want abc", out_flit); end
        checks++; if (out_stamp !== 16'd5) begin errors++; $display("FAIL single_stamp: got %0d want 5", out_stamp); end
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d want 1", fifo_count); end
        set_in(1'b0, 33'h0, 1'b1, 1'b0, 1'b1);
        step();
        checks++; if (empty !== 1'b1 || out_flit !== 33'h0) begin errors++; $display("FAIL single_drain: got empty=%0b flit=%0h want 1/0", empty, out_flit); end
    endtask

    task automatic test_fill_overflow();
        logic [32:0] exp_f[10];
        for (int i = 0; i < 10; i++) begin
            exp_f[i] = rnd33();
            set_in(1'b1, exp_f[i], 1'b1, 1'b0, 1'b0);
            step();
        end
        set_in(1'b0, 33'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (full !== 1'b1 || fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_full: got full=%0b count=%0d want 1/8", full, fifo_count); end
        checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL ovf_drop: got %0d want 2", drop_count); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (out_valid !== 1'b1 || out_flit !== exp_f[i]) begin errors++; $display("FAIL ovf_order[%0d]: got %0h want %0h", i, out_flit, exp_f[i]); end
            set_in(1'b0, 33'h0, 1'b1, 1'b0, 1'b1);
            step();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %0b want 1", empty); end
    endtask

    task automatic test_full_pushpop();
        logic [32:0] fr[8];
        for (int i = 0; i < 8; i++) begin
            fr[i] = rnd33();
            set_in(1'b1, fr[i], 1'b1, 1'b0, 1'b0);
            step();
        end
        set_in(1'b1, rnd33(), 1'b1, 1'b0, 1'b1);
        step();
        set_in(1'b0, 33'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (fifo_count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL pp_count: got %0d want 8", fifo_count); end
        checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL pp_drop: got %0d want 2", drop_count); end
        checks++; if (out_flit !== fr[1]) begin errors++; $display("FAIL pp_head: got %0h want %0h", out_flit, fr[1]); end
    endtask

    task automatic test_clear();
        repeat (2) begin
            set_in(1'b1, rnd33(), 1'b1, 1'b0, 1'b0);
            step();
        end
        repeat (5) begin
            set_in(1'b0, 33'h0, 1'b1, 1'b0, 1'b1);
            step();
        end
        checks++; if (fifo_count !== 4'd3 || drop_count !== 8'd4) begin errors++; $display("FAIL clr_pre: got count=%0d drop=%0d want 3/4", fifo_count, drop_count); end
        set_in(1'b1, rnd33(), 1'b1, 1'b1, 1'b0);
        step();
        set_in(1'b0, 33'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (fifo_count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL clr_count: got %0d want 0", fifo_count); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL clr_drop: got %0d want 0", drop_count); end
        checks++; if (out_valid !== 1'b0 || out_flit !== 33'h0) begin errors++; $display("FAIL clr_valid: got %0b/%0h want 0/0", out_valid, out_flit); end
    endtask

    task automatic test_enable();
        repeat (5) begin
            set_in(1'b1, rnd33(), 1'b0, 1'b0, 1'b0);
            step();
        end
        checks++; if (fifo_count !== 4'd0 || drop_count !== 8'd0) begin errors++; $display("FAIL en_off: got count=%0d drop=%0d want 0/0", fifo_count, drop_count); end
    endtask

    task automatic test_random();
        logic [32:0] ef;
        logic [15:0] es;
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom % 4) != 0, rnd33(), ($urandom % 8) != 0, ($urandom % 40) == 0,
                   ($urandom % 4) < ((i % 200) < 100 ? 1 : 3));
            step();
            ef = (mq_flit.size() != 0) ? mq_flit[0]  : 33'h0;
            es = (mq_flit.size() != 0) ? mq_stamp[0] : 16'h0;
            checks++; if (out_valid !== (mq_flit.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %0b want %0b", i, out_valid, mq_flit.size() != 0); end
            checks++; if (out_flit !== ef) begin errors++; $display("FAIL rnd_flit@%0d: got %0h want %0h", i, out_flit, ef); end
            checks++; if (out_stamp !== es) begin errors++; $display("FAIL rnd_stamp@%0d: got %0h want %0h", i, out_stamp, es); end
            checks++; if (fifo_count !== 4'(mq_flit.size())) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, fifo_count, mq_flit.size()); end
            checks++; if (full !== (mq_flit.size() == DEPTH) || empty !== (mq_flit.size() == 0)) begin errors++; $display("FAIL rnd_flags@%0d: got full=%0b empty=%0b", i, full, empty); end
            checks++; if (drop_count !== 8'(m_drop)) begin errors++; $display("FAIL rnd_drop@%0d: got %0d want %0d", i, drop_count, m_drop); end
        end
    endtask

    task automatic test_async_reset();
        set_in(1'b0, 33'h0, 1'b1, 1'b1, 1'b0);
        step();
        repeat (4) begin
            set_in(1'b1, rnd33(), 1'b1, 1'b0, 1'b0);
            step();
        end
        set_in(1'b0, 33'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (fifo_count !== 4'd4) begin errors++; $display("FAIL arst_pre: got %0d want 4", fifo_count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (empty !== 1'b1 || fifo_count !== 4'd0) begin errors++; $display("FAIL arst_empty: got empty=%0b count=%0d want 1/0", empty, fifo_count); end
        checks++; if (out_valid !== 1'b0 || out_flit !== 33'h0 || out_stamp !== 16'h0) begin errors++; $display("FAIL arst_out: got %0b/%0h/%0h want 0", out_valid, out_flit, out_stamp); end
        @(posedge clk);
        release_reset();
    endtask

    task automatic test_wrap_sat();
        logic [32:0] a, b;
        repeat (DEPTH + 300) begin
            set_in(1'b1, rnd33(), 1'b1, 1'b0, 1'b0);
            step();
        end
        checks++; if (drop_count !== 8'd255 || fifo_count !== 4'd8) begin errors++; $display("FAIL sat_drop: got %0d want 255", drop_count); end
        set_in(1'b0, 33'h0, 1'b1, 1'b1, 1'b0);
        step();
        set_in(1'b0, 33'h0, 1'b1, 1'b0, 1'b0);
        while ((edges % 65536) != 65535) step();
        a = rnd33(); b = rnd33();
        set_in(1'b1, a, 1'b1, 1'b0, 1'b0);
        step();
        set_in(1'b1, b, 1'b1, 1'b0, 1'b0);
        step();
        set_in(1'b0, 33'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (out_stamp !== 16'hFFFF || out_flit !== a) begin errors++; $display("FAIL wrap_ffff: got stamp=%0h want ffff", out_stamp); end
        set_in(1'b0, 33'h0, 1'b1, 1'b0, 1'b1);
        step();
        checks++; if (out_stamp !== 16'h0000 || out_flit !== b) begin errors++; $display("FAIL wrap_0000: got stamp=%0h want 0", out_stamp); end
    endtask

    initial begin
        set_in(1'b0, 33'h0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_pushpop();
        test_clear();
        test_enable();
        test_random();
        test_async_reset();
        test_wrap_sat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
